bw_io_impctl_ddr_dncal: RTL and testbench

Parametrised pulldown impedance calibration engine for the DDR impctl macro. It samples the pad comparator `above` output under `sclk` strobes and rejects noise with a consecutive-sample filter. It steps a saturating `cbd` drive code up or down and flags lock when the code dithers around the reference. Its output feeds the `cbd` bus of the pad zctl cell and the pullup calibrator downstream.

---
 rtl/bw_io_impctl_pkg.sv | 19 +
 rtl/bw_io_impctl_cmpfilt.sv | 50 +++++
 rtl/bw_io_impctl_ddr_dncal.sv | 120 ++++++++++++
 tb/tb_bw_io_impctl_ddr_dncal.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_impctl_pkg.sv
// rtl/bw_io_impctl_pkg.sv - shared types for the impctl calibration engines
package bw_io_impctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_UPDATE = 2'd3
  } impctl_cal_st_t;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } impctl_dir_t;

  localparam int FILT_CNT_W   = 4;
  localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/bw_io_impctl_cmpfilt.sv
// rtl/bw_io_impctl_cmpfilt.sv - comparator synchronizer and consecutive-sample filter
module bw_io_impctl_cmpfilt
  import bw_io_impctl_pkg::*;
#(
  parameter int FILT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_above,
  input  logic        i_sample,
  input  logic        i_clr,
  input  logic        i_hold,
  output logic        o_dir_valid,
  output impctl_dir_t o_dir
);

  logic [1:0]            r_sync;
  logic [FILT_CNT_W-1:0] r_cnt;
  logic                  r_val;
  logic                  w_above_s;
  logic                  w_take;
  logic [FILT_CNT_W-1:0] w_cnt_nxt;

  assign w_above_s = r_sync[1];
  assign w_take    = i_sample && !i_clr && !i_hold;
  // An empty filter adopts whatever value arrives, so storing above_s is always correct.
  assign w_cnt_nxt = (r_cnt == '0 || w_above_s == r_val) ? r_cnt + 1'b1 : FILT_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_val  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_above};
      if (!i_hold) begin
        if (i_clr) begin
          r_cnt <= '0;
        end else if (i_sample) begin
          r_cnt <= w_cnt_nxt;
          r_val <= w_above_s;
        end
      end
    end
  end

  assign o_dir_valid = w_take && (w_cnt_nxt == FILT_CNT_W'(FILT_DEPTH));
  assign o_dir       = impctl_dir_t'(w_above_s);

endmodule

// File: rtl/bw_io_impctl_ddr_dncal.sv
// rtl/bw_io_impctl_ddr_dncal.sv - pulldown impedance calibration FSM, code register and lock
module bw_io_impctl_ddr_dncal
  import bw_io_impctl_pkg::*;
#(
  parameter int CODE_W     = 8,
  parameter int FILT_DEPTH = 4,
  parameter int SETTLE_CYC = 7,
  parameter int LOCK_REV   = 2,
  parameter int RST_CODE   = 2 ** (CODE_W - 1)
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              above,
  input  logic              sclk,
  input  logic              cal_en,
  input  logic              freeze,
  output logic [CODE_W-1:0] cbd,
  output logic              code_upd,
  output logic              locked,
  output logic              sat
);

  localparam int                REV_W    = $clog2(LOCK_REV + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  impctl_cal_st_t          r_state, w_state_nxt;
  logic [SETTLE_CNT_W-1:0] r_settle;
  logic [REV_W-1:0]        r_rev, w_rev_inc;
  logic                    r_cal_en_d, r_have_last;
  impctl_dir_t             r_dir, r_last_dir, w_dir;
  logic                    w_dir_valid, w_cal_rise, w_at_limit;
  logic [CODE_W-1:0]       r_cbd;
  logic                    r_code_upd, r_locked, r_sat;

  bw_io_impctl_cmpfilt #(.FILT_DEPTH(FILT_DEPTH)) u_cmpfilt (
    .clk        (clk),
    .rst        (global_reset),
    .i_above    (above),
    .i_sample   (r_state == ST_SAMPLE && cal_en && sclk),
    .i_clr      (r_state != ST_SAMPLE || !cal_en),
    .i_hold     (freeze),
    .o_dir_valid(w_dir_valid),
    .o_dir      (w_dir)
  );

  assign w_cal_rise = cal_en && !r_cal_en_d;
  assign w_at_limit = (r_dir == UP) ? (r_cbd == CODE_MAX) : (r_cbd == '0);
  assign w_rev_inc  = (r_rev == REV_W'(LOCK_REV)) ? r_rev : r_rev + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    if (!freeze) begin
      case (r_state)
        ST_IDLE:   if (cal_en) w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (!cal_en) w_state_nxt = ST_IDLE;
                   else if (r_settle == '0) w_state_nxt = ST_SAMPLE;
        ST_SAMPLE: if (!cal_en) w_state_nxt = ST_IDLE;
                   else if (w_dir_valid) w_state_nxt = ST_UPDATE;
        ST_UPDATE: w_state_nxt = cal_en ? ST_SETTLE : ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      r_state     <= ST_IDLE;
      r_settle    <= '0;
      r_rev       <= '0;
      r_cal_en_d  <= 1'b0;
      r_have_last <= 1'b0;
      r_dir       <= DN;
      r_last_dir  <= DN;
      r_cbd       <= CODE_W'(RST_CODE);
      r_code_upd  <= 1'b0;
      r_locked    <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_code_upd <= 1'b0;
      if (!freeze) begin
        r_state    <= w_state_nxt;
        r_cal_en_d <= cal_en;
        // Settle window is SETTLE_CYC cycles long, counting down to zero inclusive.
        if (w_state_nxt == ST_SETTLE)
          r_settle <= (r_state != ST_SETTLE) ? SETTLE_CNT_W'(SETTLE_CYC - 1) : r_settle - 1'b1;
        else
          r_settle <= '0;
        if (w_dir_valid) r_dir <= w_dir;
        if (w_cal_rise) begin
          r_locked <= 1'b0;
          r_sat    <= 1'b0;
          r_rev    <= '0;
        end
        if (r_state == ST_UPDATE) begin
          if (w_at_limit) begin
            r_sat <= 1'b1;
          end else begin
            r_cbd      <= (r_dir == UP) ? r_cbd + 1'b1 : r_cbd - 1'b1;
            r_code_upd <= 1'b1;
          end
          if (r_have_last && r_dir != r_last_dir) begin
            r_rev <= w_rev_inc;
            if (w_rev_inc == REV_W'(LOCK_REV)) r_locked <= 1'b1;
          end else if (r_have_last) begin
            r_rev    <= '0;
            r_locked <= 1'b0;
          end
          r_last_dir  <= r_dir;
          r_have_last <= 1'b1;
        end
      end
    end
  end

  assign cbd      = r_cbd;
  assign code_upd = r_code_upd;
  assign locked   = r_locked;
  assign sat      = r_sat;

endmodule

// File: tb/tb_bw_io_impctl_ddr_dncal.sv
// tb/tb_bw_io_impctl_ddr_dncal.sv - scoreboard bench for the pulldown calibration engine
`timescale 1ns/1ps
module tb_bw_io_impctl_ddr_dncal;

  typedef struct packed {
    logic [7:0] code;
    logic       lk;
    logic       st;
  } exp_t;

  logic       clk = 1'b0;
  logic       global_reset = 1'b1;
  logic       above = 1'b0;
  logic       sclk = 1'b0;
  logic       cal_en = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] cbd;
  logic       code_upd, locked, sat;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   cyc = 0;
  int   t_last = 0;
  bit   period_chk = 1'b0;
  bit   have_prev = 1'b0;
  bit   model_en = 1'b0;

  bw_io_impctl_ddr_dncal dut (
    .clk         (clk),
    .global_reset(global_reset),
    .above       (above),
    .sclk        (sclk),
    .cal_en      (cal_en),
    .freeze      (freeze),
    .cbd         (cbd),
    .code_upd    (code_upd),
    .locked      (locked),
    .sat         (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Comparator model (threshold 0x84) and scoreboard monitor.
  always @(negedge clk) begin
    if (model_en) above = (cbd < 8'h84);
    if (!global_reset && code_upd) begin
      n_pulse++;
      if (period_chk && have_prev) check("step_period", cyc - t_last, 12);
      have_prev = 1'b1;
      t_last = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_upd: code_upd with cbd 0x%0h, expected no pulse", cbd);
      end else begin
        e_mon = exp_q.pop_front();
        check("upd_cbd", cbd, e_mon.code);
        check("upd_locked", locked, e_mon.lk);
        check("upd_sat", sat, e_mon.st);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic qsample(input logic v);
    above = v;
    tick(3);
    sclk = 1'b1;
    tick(1);
    sclk = 1'b0;
  endtask

  task automatic push(input logic [7:0] c, input logic lk, input logic st);
    exp_t e;
    e.code = c;
    e.lk   = lk;
    e.st   = st;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick(1);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d responses pending after %0d cycles, expected 0", name, exp_q.size(), max);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    cal_en = 1'b0;
    sclk = 1'b0;
    freeze = 1'b0;
    model_en = 1'b0;
    period_chk = 1'b0;
    tick(3);
    global_reset = 1'b0;
    tick(1);
    check("rst_cbd", cbd, 8'h80);
    check("rst_code_upd", code_upd, 0);
    check("rst_locked", locked, 0);
    check("rst_sat", sat, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    above = 1'b1;
    do_reset();
    sclk = 1'b1;
    tick(20);
    check("idle_cbd", cbd, 8'h80);
    check("idle_pulses", n_pulse, 0);
    sclk = 1'b0;

    // Ramp to full scale, then saturate.
    for (int c = 'h81; c <= 'hFF; c++) push(c[7:0], 1'b0, 1'b0);
    have_prev = 1'b0;
    period_chk = 1'b1;
    above = 1'b1;
    cal_en = 1'b1;
    sclk = 1'b1;
    drain("ramp_drain", 127 * 12 + 40);
    tick(16);
    period_chk = 1'b0;
    check("sat_flag", sat, 1);
    check("sat_cbd", cbd, 8'hFF);
    check("sat_locked", locked, 0);

    // Filter: 1,1,1 then 0,0,0,0 gives one decrement.
    do_reset();
    cal_en = 1'b1;
    tick(10);
    qsample(1'b1);
    qsample(1'b1);
    qsample(1'b1);
    push(8'h7F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) qsample(1'b0);
    drain("filt_drain", 20);
    tick(5);
    check("filt_cbd", cbd, 8'h7F);

    // Lock around threshold 0x84, then reset during the following UPDATE.
    do_reset();
    model_en = 1'b1;
    tick(1);
    push(8'h81, 1'b0, 1'b0);
    push(8'h82, 1'b0, 1'b0);
    push(8'h83, 1'b0, 1'b0);
    push(8'h84, 1'b0, 1'b0);
    push(8'h83, 1'b0, 1'b0);
    push(8'h84, 1'b1, 1'b0);
    push(8'h83, 1'b1, 1'b0);
    cal_en = 1'b1;
    sclk = 1'b1;
    drain("lock_drain", 150);
    check("lock_flag", locked, 1);
    for (int i = 0; i < 20 && cyc < t_last + 11; i++) tick(1);
    global_reset = 1'b1;
    cal_en = 1'b0;
    model_en = 1'b0;
    sclk = 1'b0;
    #1;
    check("rst_upd_cbd", cbd, 8'h80);
    check("rst_upd_locked", locked, 0);
    check("rst_upd_code_upd", code_upd, 0);
    tick(2);
    global_reset = 1'b0;
    tick(12);
    check("rst_upd_hold", cbd, 8'h80);

    // sclk gating and freeze.
    do_reset();
    above = 1'b1;
    cal_en = 1'b1;
    tick(50);
    check("sclk_gate_cbd", cbd, 8'h80);
    qsample(1'b1);
    qsample(1'b1);
    freeze = 1'b1;
    sclk = 1'b1;
    tick(20);
    check("freeze_cbd", cbd, 8'h80);
    freeze = 1'b0;
    sclk = 1'b0;
    push(8'h81, 1'b0, 1'b0);
    qsample(1'b1);
    tick(3);
    check("freeze_one_more", cbd, 8'h80);
    check("freeze_pending", exp_q.size(), 1);
    qsample(1'b1);
    drain("freeze_drain", 5);
    check("freeze_step", cbd, 8'h81);

    // cal_en dropped mid-SAMPLE: code held, filter restarts.
    tick(12);
    qsample(1'b1);
    qsample(1'b1);
    cal_en = 1'b0;
    tick(3);
    check("calen_drop_cbd", cbd, 8'h81);
    cal_en = 1'b1;
    tick(10);
    qsample(1'b1);
    qsample(1'b1);
    tick(3);
    check("calen_filter_clr", cbd, 8'h81);
    push(8'h82, 1'b0, 1'b0);
    qsample(1'b1);
    qsample(1'b1);
    drain("calen_drain", 5);
    check("calen_step", cbd, 8'h82);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
